// File: rtl/mms_pkg.sv
// Shared types and constants for the max/min stream controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
`timescale 1ns/1ps
package mms_pkg;

    // Default datapath width for numbers and results.
    localparam int DEF_DATA_W = 8;

    // Reduction mode as latched from in_select on the first beat of a frame.
    localparam logic MODE_MAX = 1'b0;
    localparam logic MODE_MIN = 1'b1;

    // Controller sequencing states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        REDUCE = 2'd2,
        OUT    = 2'd3
    } mms_state_e;

endpackage

// File: rtl/mms_reduce4.sv
// Four-input unsigned max/min selector built as a 2-level pairwise compare tree.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs.
//
// Ports:
//   a0_i..a3_i : operands (unsigned)
//   mode_i     : MODE_MAX selects the largest, MODE_MIN the smallest
//   y_o        : selected operand
`timescale 1ns/1ps
module mms_reduce4
    import mms_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic [DATA_W-1:0] a0_i,
    input  logic [DATA_W-1:0] a1_i,
    input  logic [DATA_W-1:0] a2_i,
    input  logic [DATA_W-1:0] a3_i,
    input  logic              mode_i,
    output logic [DATA_W-1:0] y_o
);

    function automatic logic [DATA_W-1:0] pick(
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b,
        input logic              mode
    );
        if (mode == MODE_MIN) begin
            pick = (b < a) ? b : a;
        end else begin
            pick = (b > a) ? b : a;
        end
    endfunction

    logic [DATA_W-1:0] lvl0_lo;
    logic [DATA_W-1:0] lvl0_hi;

    assign lvl0_lo = pick(a0_i, a1_i, mode_i);
    assign lvl0_hi = pick(a2_i, a3_i, mode_i);
    assign y_o     = pick(lvl0_lo, lvl0_hi, mode_i);

endmodule

// File: rtl/mms_stream_ctrl.sv
// Frame-level max/min of an unsigned stream: beats gathered in groups of 4, each group reduced and folded into an accumulator.
// Latency: last beat accepted at T -> REDUCE at T+1 -> out_valid at T+2; one REDUCE bubble after every 4th beat.
// Backpressure: in_ready low in REDUCE/OUT and during reset; result held stable in OUT until out_ready.
//
// Ports:
//   clk, reset                      : clock, synchronous active-high reset
//   in_valid/in_ready/in_data       : input beat handshake and number
//   in_last, in_select              : end-of-frame marker, 1=min/0=max (first beat only)
//   out_valid/out_ready             : result handshake
//   out_result, out_count           : frame max/min and saturating element count
`timescale 1ns/1ps
module mms_stream_ctrl
    import mms_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    input  logic              in_select,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [CNT_W-1:0]  out_count
);

    mms_state_e        state_q,      state_d;
    logic [DATA_W-1:0] slot_q [4];
    logic [DATA_W-1:0] slot_d [4];
    // idx counts filled slots 0..4, so it needs 3 bits to tell "full" from "empty".
    logic [2:0]        idx_q,        idx_d;
    logic [CNT_W-1:0]  count_q,      count_d;
    logic [DATA_W-1:0] acc_q,        acc_d;
    logic              mode_q,       mode_d;
    logic              first_grp_q,  first_grp_d;
    logic              last_seen_q,  last_seen_d;
    logic              out_valid_q,  out_valid_d;
    logic [DATA_W-1:0] out_result_q, out_result_d;
    logic [CNT_W-1:0]  out_count_q,  out_count_d;

    logic              accept;
    logic [DATA_W-1:0] red_in1, red_in2, red_in3;
    logic [DATA_W-1:0] grp_val;
    logic [DATA_W-1:0] fold_val;
    logic [DATA_W-1:0] acc_new;
    logic [CNT_W-1:0]  count_inc;

    assign in_ready   = !reset && ((state_q == IDLE) || (state_q == FILL));
    assign accept     = in_valid && in_ready;
    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_count  = out_count_q;

    assign count_inc = (count_q == {CNT_W{1'b1}}) ? count_q : count_q + 1'b1;

    // Unfilled slots repeat slot0, which can never win against itself, so a
    // short final group reduces correctly for both max and min.
    assign red_in1 = (idx_q > 3'd1) ? slot_q[1] : slot_q[0];
    assign red_in2 = (idx_q > 3'd2) ? slot_q[2] : slot_q[0];
    assign red_in3 = (idx_q > 3'd3) ? slot_q[3] : slot_q[0];

    mms_reduce4 #(
        .DATA_W (DATA_W)
    ) u_reduce4 (
        .a0_i   (slot_q[0]),
        .a1_i   (red_in1),
        .a2_i   (red_in2),
        .a3_i   (red_in3),
        .mode_i (mode_q),
        .y_o    (grp_val)
    );

    // Single comparator folding the group result into the running value.
    always_comb begin
        fold_val = acc_q;
        if (mode_q == MODE_MIN) begin
            if (grp_val < acc_q) fold_val = grp_val;
        end else begin
            if (grp_val > acc_q) fold_val = grp_val;
        end
    end

    assign acc_new = first_grp_q ? grp_val : fold_val;

    always_comb begin
        state_d      = state_q;
        slot_d       = slot_q;
        idx_d        = idx_q;
        count_d      = count_q;
        acc_d        = acc_q;
        mode_d       = mode_q;
        first_grp_d  = first_grp_q;
        last_seen_d  = last_seen_q;
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_count_d  = out_count_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    mode_d      = in_select;
                    slot_d[0]   = in_data;
                    idx_d       = 3'd1;
                    count_d     = {{(CNT_W-1){1'b0}}, 1'b1};
                    first_grp_d = 1'b1;
                    last_seen_d = in_last;
                    state_d     = in_last ? REDUCE : FILL;
                end
            end
            FILL: begin
                if (accept) begin
                    slot_d[idx_q[1:0]] = in_data;
                    count_d            = count_inc;
                    idx_d              = idx_q + 3'd1;
                    if (in_last) begin
                        last_seen_d = 1'b1;
                        state_d     = REDUCE;
                    end else if (idx_q == 3'd3) begin
                        last_seen_d = 1'b0;
                        state_d     = REDUCE;
                    end
                end
            end
            REDUCE: begin
                acc_d = acc_new;
                if (last_seen_q) begin
                    out_result_d = acc_new;
                    out_count_d  = count_q;
                    out_valid_d  = 1'b1;
                    state_d      = OUT;
                end else begin
                    idx_d       = 3'd0;
                    first_grp_d = 1'b0;
                    state_d     = FILL;
                end
            end
            OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            for (int i = 0; i < 4; i++) slot_q[i] <= '0;
            idx_q        <= 3'd0;
            count_q      <= '0;
            acc_q        <= '0;
            mode_q       <= MODE_MAX;
            first_grp_q  <= 1'b0;
            last_seen_q  <= 1'b0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            slot_q       <= slot_d;
            idx_q        <= idx_d;
            count_q      <= count_d;
            acc_q        <= acc_d;
            mode_q       <= mode_d;
            first_grp_q  <= first_grp_d;
            last_seen_q  <= last_seen_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_count_q  <= out_count_d;
        end
    end

endmodule
